// File: rtl/avg_pool_sched.sv
// Round-robin scheduler that shares one average-pool datapath between NUM_REQ requesters.
// Optional perf counters (perf_windows, perf_stall) are built when AVG_POOL_SCHED_PERF_EN is defined.
module avg_pool_sched #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 32,
    parameter int OUT_W    = 8,
    parameter int WIN      = 4,
    parameter int POOL_LAT = 5,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      pool_clr,
    output logic                      pool_enable,
    output logic [DATA_W-1:0]         pool_data,
    input  logic [OUT_W-1:0]          pool_avg,
    output logic                      res_valid,
    output logic [ID_W-1:0]           res_id,
    output logic [OUT_W-1:0]          res_data,
    input  logic                      res_ready
`ifdef AVG_POOL_SCHED_PERF_EN
    ,
    output logic [15:0]               perf_windows,
    output logic [15:0]               perf_stall
`endif
);

    localparam int SCNT_W = $clog2(WIN + 1);
    localparam int LCNT_W = $clog2(POOL_LAT + 1);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESP} state_t;

    state_t              state;
    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     pick;
    logic [SCNT_W-1:0]   scnt;
    logic [LCNT_W-1:0]   lcnt;
    logic                hs;
    logic [DATA_W-1:0]   sample;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Descending scan so the lowest offset from rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)]) pick = wrap_add(rr_ptr, k);
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == FEED) req_ready[grant] = 1'b1;
    end

    assign hs     = (state == FEED) && req_valid[grant];
    assign sample = req_data[grant*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            scnt        <= '0;
            lcnt        <= '0;
            res_valid   <= 1'b0;
            res_id      <= '0;
            res_data    <= '0;
            pool_enable <= 1'b0;
            pool_data   <= '0;
            pool_clr    <= 1'b1;
        end else begin
            pool_clr    <= 1'b0;
            pool_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant    <= pick;
                        pool_clr <= 1'b1;
                        scnt     <= '0;
                        state    <= FEED;
                    end
                end
                FEED: begin
                    if (hs) begin
                        pool_enable <= 1'b1;
                        pool_data   <= sample;
                        scnt        <= scnt + 1'b1;
                        if (scnt == SCNT_W'(WIN - 1)) begin
                            lcnt  <= '0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    lcnt <= lcnt + 1'b1;
                    if (lcnt == LCNT_W'(POOL_LAT - 1)) begin
                        res_data  <= pool_avg;
                        res_id    <= grant;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= wrap_add(grant, 1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AVG_POOL_SCHED_PERF_EN
    logic stall_now;

    always_comb begin
        stall_now = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && (ID_W'(i) != grant) && (state != IDLE)) stall_now = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_windows <= '0;
            perf_stall   <= '0;
        end else begin
            if (state == RESP && res_ready && perf_windows != 16'hFFFF)
                perf_windows <= perf_windows + 16'd1;
            if (stall_now && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_avg_pool_sched.sv
// Scoreboard bench for avg_pool_sched: random windows per requester, round-robin model, pool stand-in.
module tb_avg_pool_sched;
    localparam int NUM_REQ  = 4;
    localparam int DATA_W   = 32;
    localparam int OUT_W    = 8;
    localparam int WIN      = 4;
    localparam int POOL_LAT = 5;
    localparam int ID_W     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      pool_clr, pool_enable;
    logic [DATA_W-1:0]         pool_data;
    logic [OUT_W-1:0]          pool_avg;
    logic                      res_valid;
    logic [ID_W-1:0]           res_id;
    logic [OUT_W-1:0]          res_data;
    logic                      res_ready = 1'b0;
`ifdef AVG_POOL_SCHED_PERF_EN
    logic [15:0] perf_windows, perf_stall;
`endif

    avg_pool_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OUT_W(OUT_W), .WIN(WIN), .POOL_LAT(POOL_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .pool_clr(pool_clr), .pool_enable(pool_enable), .pool_data(pool_data), .pool_avg(pool_avg),
        .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .res_ready(res_ready)
`ifdef AVG_POOL_SCHED_PERF_EN
        , .perf_windows(perf_windows), .perf_stall(perf_stall)
`endif
    );

    // Stand-in pool unit: accumulates strobed samples, result = floor(sum / 4).
    longint acc = 0;
    always @(posedge clk) begin
        if (pool_clr) acc <= 0;
        else if (pool_enable) acc <= acc + longint'($signed(pool_data));
    end
    assign pool_avg = OUT_W'(acc >>> 2);

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] samp_q[NUM_REQ][$];
    logic [OUT_W-1:0]  res_q[NUM_REQ][$];
    logic [DATA_W-1:0] exp_pool_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int p, input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++)
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        return 0;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit                 prev_rst = 1'b1;
    bit                 prev_idle = 1'b1;
    logic [NUM_REQ-1:0] last_valid = '0;
    bit                 have_grant = 1'b0;
    bit                 pend_release = 1'b0;
    int                 cur_g = 0;
    int                 rr_m = 0;
    int                 win_hs = 0;
    int                 en_cnt = 0;
    int                 since = 0;
    int                 windows_done = 0;
    bit                 prv_rv = 1'b0, prv_rr = 1'b0;
    logic [ID_W-1:0]    prv_id = '0;
    logic [OUT_W-1:0]   prv_data = '0;
    logic [NUM_REQ-1:0] exp_rdy;
    bit                 exp_clr;

    always @(negedge clk) begin
        if (prev_rst) begin
            chk("pool_clr_in_reset", pool_clr, 1);
            have_grant = 0; pend_release = 0; win_hs = 0; en_cnt = 0; since = 0;
            rr_m = 0; windows_done = 0;
        end else begin
            if (pend_release) begin
                have_grant = 0;
                pend_release = 0;
            end
            exp_clr = prev_idle && (last_valid != '0);
            chk("pool_clr", pool_clr, exp_clr);
            if (exp_clr) begin
                cur_g = rr_pick(rr_m, last_valid);
                have_grant = 1; win_hs = 0; en_cnt = 0;
            end
            exp_rdy = '0;
            if (have_grant && win_hs < WIN) exp_rdy[cur_g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if ((req_valid & req_ready) != '0) win_hs++;
            if (pool_enable) begin
                if (exp_pool_q.size() == 0) chk("pool_enable_unexpected", 1, 0);
                else chk("pool_data", pool_data, exp_pool_q.pop_front());
                en_cnt++;
                since = 0;
            end else begin
                since++;
            end
            if (prv_rv && !prv_rr)
                chk("res_hold", {res_valid, res_id, res_data}, {1'b1, prv_id, prv_data});
            else if (prv_rv && prv_rr)
                chk("res_drop", res_valid, 0);
            if (res_valid && !prv_rv) begin
                chk("drain_latency", since, POOL_LAT);
                chk("window_samples", en_cnt, WIN);
            end
            if (res_valid && res_ready) begin
                chk("res_id", res_id, cur_g);
                if (res_q[cur_g].size() == 0) chk("res_unexpected", 1, 0);
                else chk("res_data", res_data, res_q[cur_g].pop_front());
                rr_m = (cur_g + 1) % NUM_REQ;
                pend_release = 1;
                windows_done++;
            end
        end
        prv_rv = res_valid; prv_rr = res_ready; prv_id = res_id; prv_data = res_data;
        prev_idle = !have_grant;
        last_valid = req_valid;
        prev_rst = rst;
    end

    // ---------------- stimulus ----------------
    int mode = 0;
    bit bp_hold = 1'b0;
    bit tog = 1'b0;
    int hs_total = 0;

    task automatic cycle();
        logic [NUM_REQ-1:0] hs;
        bit v;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i] && samp_q[i].size() > 0) begin
                exp_pool_q.push_back(samp_q[i].pop_front());
                hs_total++;
            end
        end
        tog = ~tog;
        for (int i = 0; i < NUM_REQ; i++) begin
            v = 1'b0;
            if (samp_q[i].size() > 0) begin
                req_data[i*DATA_W +: DATA_W] = samp_q[i][0];
                case (mode)
                    0: v = 1'b1;
                    1: v = ($urandom_range(0, 3) != 0);
                    default: v = (i == 1) ? tog : 1'b1;
                endcase
            end else begin
                req_data[i*DATA_W +: DATA_W] = $urandom;
            end
            req_valid[i] = v;
        end
        res_ready = bp_hold ? 1'b0 : ((mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1);
    endtask

    task automatic add_window(input int i, input int fixed);
        longint s;
        int x;
        s = 0;
        for (int k = 0; k < WIN; k++) begin
            x = (fixed != 0) ? fixed * (k + 1) : int'($urandom_range(0, 2000)) - 1000;
            samp_q[i].push_back(DATA_W'(x));
            s += x;
        end
        res_q[i].push_back(OUT_W'(s >>> 2));
    endtask

    function automatic bit all_done();
        if (exp_pool_q.size() != 0) return 0;
        for (int i = 0; i < NUM_REQ; i++)
            if (samp_q[i].size() != 0 || res_q[i].size() != 0) return 0;
        return 1;
    endfunction

    task automatic run_until_done(input int limit, input string name);
        int n;
        n = 0;
        while (!all_done() && n < limit) begin
            cycle();
            n++;
        end
        if (!all_done()) chk({name, "_timeout"}, n, 0);
        repeat (3) cycle();
    endtask

    task automatic check_reset(input string name);
        chk({name, "_res_valid"}, res_valid, 0);
        chk({name, "_res_id"}, res_id, 0);
        chk({name, "_res_data"}, res_data, 0);
        chk({name, "_pool_enable"}, pool_enable, 0);
        chk({name, "_pool_data"}, pool_data, 0);
        chk({name, "_pool_clr"}, pool_clr, 1);
        chk({name, "_req_ready"}, req_ready, 0);
    endtask

    initial begin
        int n, base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("init");
        @(posedge clk);
        #1 rst = 1'b0;

        // single requester 2 with 10,20,30,40 -> average 25
        mode = 0;
        add_window(2, 10);
        run_until_done(200, "single");

        // all requesters continuously valid, two windows each
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++) add_window(i, 0);
        run_until_done(400, "fair");

        // requester 1 valid toggling every other cycle
        mode = 2;
        add_window(1, 0);
        run_until_done(200, "bubble");

        // result backpressure for 20 cycles
        mode = 0;
        add_window(0, 0);
        bp_hold = 1'b1;
        n = 0;
        while (!res_valid && n < 100) begin
            cycle();
            n++;
        end
        if (!res_valid) chk("bp_wait_timeout", n, 0);
        repeat (20) cycle();
        bp_hold = 1'b0;
        run_until_done(100, "backpressure");

        // reset in FEED after two samples
        add_window(3, 0);
        base = hs_total;
        n = 0;
        while (hs_total - base < 2 && n < 50) begin
            cycle();
            n++;
        end
        if (hs_total - base < 2) chk("rst_wait_timeout", n, 0);
        rst = 1'b1;
        cycle();
        for (int i = 0; i < NUM_REQ; i++) begin
            samp_q[i].delete();
            res_q[i].delete();
        end
        exp_pool_q.delete();
        rst = 1'b0;
        req_valid = '0;
        @(negedge clk);
        check_reset("midrst");
        add_window(3, 0);
        run_until_done(200, "after_rst");

        // randomized windows, bubbles and res_ready
        mode = 1;
        for (int w = 0; w < 16; w++) add_window(int'($urandom_range(0, NUM_REQ - 1)), 0);
        run_until_done(3000, "random");

`ifdef AVG_POOL_SCHED_PERF_EN
        chk("perf_windows", perf_windows, windows_done);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
